// File: rtl/edge_binarize_if.sv
// rtl/edge_binarize_if.sv - pixel stream and frame status bundle for edge_binarize
interface edge_binarize_if #(
  parameter int CNT_W = 17
) ();

  // upstream side: Sobel magnitude stream plus frame control
  logic             frame_reset;
  logic [7:0]       din;
  logic             din_valid;
  logic [7:0]       thresh;

  // downstream side: binarized, position-tagged pixels and frame statistics
  logic [7:0]       dout;
  logic             dout_valid;
  logic [9:0]       col;
  logic [9:0]       row;
  logic             sof;
  logic             eol;
  logic             eof;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             frame_abort;

  // producer of pixels / consumer of results (testbench or upstream glue)
  modport master (
    output frame_reset, din, din_valid, thresh,
    input  dout, dout_valid, col, row, sof, eol, eof,
    input  edge_count, count_valid, frame_abort
  );

  // the binarizer itself
  modport slave (
    input  frame_reset, din, din_valid, thresh,
    output dout, dout_valid, col, row, sof, eol, eof,
    output edge_count, count_valid, frame_abort
  );

endinterface

// File: rtl/edge_binarize.sv
// rtl/edge_binarize.sv - threshold Sobel magnitudes, tag positions, count edges per frame
module edge_binarize #(
  parameter int IMG_W = 318,
  parameter int IMG_H = 254,
  parameter int CNT_W = 17
) (
  input logic           clk,
  input logic           rst_n,
  edge_binarize_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);

  // frame tracking state
  state_t           state_q,   state_d;
  logic [7:0]       thr_q,     thr_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [9:0]       col_cnt_q, col_cnt_d;
  logic [9:0]       row_cnt_q, row_cnt_d;

  // registered outputs
  logic [7:0]       dout_q,        dout_d;
  logic             dout_valid_q,  dout_valid_d;
  logic [9:0]       col_q,         col_d;
  logic [9:0]       row_q,         row_d;
  logic             sof_q,         sof_d;
  logic             eol_q,         eol_d;
  logic             eof_q,         eof_d;
  logic [CNT_W-1:0] edge_count_q,  edge_count_d;
  logic             count_valid_q, count_valid_d;
  logic             abort_q,       abort_d;

  // per-pixel decode helpers
  logic             first_px;
  logic [7:0]       thr_eff;
  logic             is_edge;
  logic [9:0]       cur_col;
  logic [9:0]       cur_row;
  logic             last_col;
  logic             last_px;
  logic [CNT_W-1:0] cnt_inc;

  // decode the incoming pixel; the first pixel of a frame uses the live threshold
  // because thr_q only picks it up on this same edge
  always_comb begin
    first_px = (state_q == S_IDLE);
    thr_eff  = first_px ? bus.thresh : thr_q;
    is_edge  = (bus.din >= thr_eff);
    cur_col  = first_px ? 10'd0 : col_cnt_q;
    cur_row  = first_px ? 10'd0 : row_cnt_q;
    last_col = (cur_col == LAST_COL);
    last_px  = last_col && (cur_row == LAST_ROW);
    cnt_inc  = (first_px ? '0 : run_cnt_q) + CNT_W'(is_edge);
  end

  // next-state and output decode: frame_reset beats din_valid, markers default low
  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    run_cnt_d     = run_cnt_q;
    col_cnt_d     = col_cnt_q;
    row_cnt_d     = row_cnt_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    col_d         = col_q;
    row_d         = row_q;
    sof_d         = 1'b0;
    eol_d         = 1'b0;
    eof_d         = 1'b0;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    abort_d       = 1'b0;

    if (bus.frame_reset) begin
      abort_d   = (state_q == S_ACTIVE);
      state_d   = S_IDLE;
      run_cnt_d = '0;
      col_cnt_d = 10'd0;
      row_cnt_d = 10'd0;
    end else if (bus.din_valid) begin
      if (first_px) begin
        thr_d = bus.thresh;
      end
      dout_valid_d = 1'b1;
      dout_d       = is_edge ? 8'hFF : 8'h00;
      col_d        = cur_col;
      row_d        = cur_row;
      sof_d        = first_px;
      eol_d        = last_col;
      eof_d        = last_px;
      if (last_px) begin
        edge_count_d  = cnt_inc;
        count_valid_d = 1'b1;
        run_cnt_d     = '0;
        col_cnt_d     = 10'd0;
        row_cnt_d     = 10'd0;
        state_d       = S_IDLE;
      end else begin
        run_cnt_d = cnt_inc;
        state_d   = S_ACTIVE;
        if (last_col) begin
          col_cnt_d = 10'd0;
          row_cnt_d = cur_row + 10'd1;
        end else begin
          col_cnt_d = cur_col + 10'd1;
          row_cnt_d = cur_row;
        end
      end
    end
  end

  // state, threshold and position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      thr_q     <= 8'd0;
      run_cnt_q <= '0;
      col_cnt_q <= 10'd0;
      row_cnt_q <= 10'd0;
    end else begin
      state_q   <= state_d;
      thr_q     <= thr_d;
      run_cnt_q <= run_cnt_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // output registers, one cycle behind the accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q        <= 8'd0;
      dout_valid_q  <= 1'b0;
      col_q         <= 10'd0;
      row_q         <= 10'd0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      eof_q         <= 1'b0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      col_q         <= col_d;
      row_q         <= row_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      eof_q         <= eof_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      abort_q       <= abort_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.col         = col_q;
  assign bus.row         = row_q;
  assign bus.sof         = sof_q;
  assign bus.eol         = eol_q;
  assign bus.eof         = eof_q;
  assign bus.edge_count  = edge_count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_edge_binarize.sv
// tb/tb_edge_binarize.sv - directed self-checking bench for edge_binarize on a reduced 8x4 frame
module tb_edge_binarize;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int NPIX  = W * H;
  localparam int CNT_W = 6;

  logic clk;
  logic rst_n;

  edge_binarize_if #(.CNT_W(CNT_W)) bus ();

  edge_binarize #(
    .IMG_W(W),
    .IMG_H(H),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] last_d;
  logic [9:0] last_c;
  logic [9:0] last_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {30'd0, bus.dout_valid, bus.dout, bus.col, bus.row,
            bus.sof, bus.eol, bus.eof, bus.count_valid, bus.frame_abort};
  endfunction

  function automatic logic [63:0] mk(input logic dv, input logic [7:0] d, input logic [9:0] c,
                                     input logic [9:0] r, input logic s, input logic el,
                                     input logic ef, input logic cv, input logic ab);
    return {30'd0, dv, d, c, r, s, el, ef, cv, ab};
  endfunction

  task automatic drive(input logic [7:0] d, input logic v, input logic fr, input logic [7:0] th);
    @(negedge clk);
    bus.din         = d;
    bus.din_valid   = v;
    bus.frame_reset = fr;
    bus.thresh      = th;
    @(posedge clk);
    #1;
  endtask

  // One frame: din = base + step*i, threshold th switching to th2 at pixel chg_at.
  // abort_at < NPIX raises frame_reset together with that pixel and stops there.
  task automatic run_frame(input string tag, input logic [7:0] th, input logic [7:0] th2,
                           input int chg_at, input logic [7:0] base, input logic [7:0] step,
                           input bit gaps, input int abort_at, input int exp_cnt,
                           input int prev_cnt);
    logic [7:0] d;
    logic [7:0] t;
    logic       e;
    logic [9:0] c;
    logic [9:0] r;
    int sofs, eols, eofs, beats;
    sofs = 0; eols = 0; eofs = 0; beats = 0;
    for (int i = 0; i < NPIX; i++) begin
      d = base + 8'(step * i);
      t = (i >= chg_at) ? th2 : th;
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
          drive(8'hA5, 1'b0, 1'b0, t);
          check_eq({tag, "_gap"}, outs(), mk(1'b0, last_d, last_c, last_r, 0, 0, 0, 0, 0));
        end
      end
      if (i == abort_at) begin
        drive(d, 1'b1, 1'b1, t);
        check_eq({tag, "_abort"}, outs(), mk(1'b0, last_d, last_c, last_r, 0, 0, 0, 0, 1));
        check_eq({tag, "_abort_cnt"}, 64'(bus.edge_count), 64'(prev_cnt));
        return;
      end
      drive(d, 1'b1, 1'b0, t);
      e = (d >= th);
      c = 10'(i % W);
      r = 10'(i / W);
      check_eq({tag, "_px"}, outs(),
               mk(1'b1, e ? 8'hFF : 8'h00, c, r, i == 0, c == 10'(W - 1),
                  i == NPIX - 1, i == NPIX - 1, 1'b0));
      last_d = e ? 8'hFF : 8'h00;
      last_c = c;
      last_r = r;
      beats += int'(bus.dout_valid);
      sofs  += int'(bus.sof);
      eols  += int'(bus.eol);
      eofs  += int'(bus.eof);
    end
    check_eq({tag, "_cnt"}, 64'(bus.edge_count), 64'(exp_cnt));
    if (gaps) begin
      check_eq({tag, "_beats"}, 64'(beats), 64'(NPIX));
      check_eq({tag, "_sofs"}, 64'(sofs), 64'd1);
      check_eq({tag, "_eols"}, 64'(eols), 64'(H));
      check_eq({tag, "_eofs"}, 64'(eofs), 64'd1);
    end
  endtask

  initial begin
    last_d = 8'd0;
    last_c = 10'd0;
    last_r = 10'd0;
    rst_n           = 1'b0;
    bus.din         = 8'd0;
    bus.din_valid   = 1'b0;
    bus.frame_reset = 1'b0;
    bus.thresh      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", outs(), 64'd0);
    check_eq("reset_cnt", 64'(bus.edge_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back frames: ramp, extremes, latched threshold
    run_frame("ramp",   8'd128, 8'd128, NPIX, 8'd0,   8'd8, 1'b0, NPIX, 16, 0);
    run_frame("thr0",   8'd0,   8'd0,   NPIX, 8'd0,   8'd0, 1'b0, NPIX, 32, 0);
    run_frame("thr255a",8'd255, 8'd255, NPIX, 8'd254, 8'd0, 1'b0, NPIX, 0,  0);
    run_frame("thr255b",8'd255, 8'd255, NPIX, 8'd255, 8'd0, 1'b0, NPIX, 32, 0);
    run_frame("thrchg", 8'd10,  8'd200, 5,    8'd100, 8'd0, 1'b0, NPIX, 32, 0);

    // random din_valid gaps
    run_frame("gaps",   8'd100, 8'd100, NPIX, 8'd3,   8'd7, 1'b1, NPIX, 18, 0);

    // abort mid-frame keeps the previous count
    run_frame("abort",  8'd128, 8'd128, NPIX, 8'd0,   8'd8, 1'b0, 10,   0,  18);
    drive(8'd0, 1'b0, 1'b1, 8'd128);
    check_eq("idle_reset", outs(), mk(1'b0, last_d, last_c, last_r, 0, 0, 0, 0, 0));
    drive(8'd200, 1'b1, 1'b1, 8'd128);
    check_eq("idle_reset_px", outs(), mk(1'b0, last_d, last_c, last_r, 0, 0, 0, 0, 0));
    check_eq("idle_reset_cnt", 64'(bus.edge_count), 64'd18);
    run_frame("after",  8'd128, 8'd128, NPIX, 8'd0,   8'd8, 1'b0, NPIX, 16, 0);

    // asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) drive(8'(i * 40), 1'b1, 1'b0, 8'd50);
    @(negedge clk);
    bus.din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_outs", outs(), 64'd0);
    check_eq("async_cnt", 64'(bus.edge_count), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_d = 8'd0;
    last_c = 10'd0;
    last_r = 10'd0;
    run_frame("postrst", 8'd128, 8'd128, NPIX, 8'd0, 8'd8, 1'b0, NPIX, 16, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
